cp0_ctrl: RTL
=============

CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning CP0 register and data width; only 32 is legal.
REQ-002 SHALL have parameter N_HWINT, default 6, meaning the number of hardware interrupt lines; legal range is 1..6.
REQ-003 SHALL have parameter TIMER_EN, default 1, meaning a 1 enables the Count/Compare timer interrupt on IP7.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port we_i, input, 1 bit: MTC0 write enable.
REQ-007 SHALL have port waddr_i, input, 5 bits: MTC0 register address.
REQ-008 SHALL have port wdata_i, input, DATA_W bits: MTC0 data.
REQ-009 SHALL have port raddr_i, input, 5 bits: MFC0 register address.
REQ-010 SHALL have port rdata_o, output, DATA_W bits: MFC0 read data, combinational.
REQ-011 SHALL have port int_i, input, N_HWINT bits: hardware interrupt levels.
REQ-012 SHALL have port exc_valid_i, input, 1 bit: exception commit strobe.
REQ-013 SHALL have port exc_code_i, input, 5 bits: ExcCode of the committed exception.
REQ-014 SHALL have port exc_pc_i, input, DATA_W bits: PC of the faulting instruction.
REQ-015 SHALL have port exc_bd_i, input, 1 bit: a 1 means the faulting instruction is in a delay slot.
REQ-016 SHALL have port exc_badvaddr_i, input, DATA_W bits: faulting address.
REQ-017 SHALL have port eret_i, input, 1 bit: ERET commit strobe.
REQ-018 SHALL have port status_o, cause_o, epc_o, input/output direction output, DATA_W bits each: live register values.
REQ-019 SHALL have port int_req_o, output, 1 bit: interrupt request to the pipeline, registered.
REQ-020 SHALL have port timer_int_o, output, 1 bit: timer interrupt pending (Cause bit 15).

Function
REQ-021 SHALL map registers as BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14; any other raddr_i reads 0.
REQ-022 SHALL increment Count by 1 every cycle, wrapping from 0xFFFFFFFF to 0; a same-cycle MTC0 to Count loads wdata_i instead of incrementing.
REQ-023 SHALL, when TIMER_EN=1, set Cause[15] one cycle after Count==Compare with Compare!=0, hold it sticky, and clear it on any MTC0 to Compare; if the write and the match fall in the same cycle, the clear wins.
REQ-024 SHALL sample int_i into Cause[10+N_HWINT-1:10] every cycle; Cause IP bits not driven by int_i or the timer read 0.
REQ-025 SHALL accept MTC0 writes to Status bits [15:8] (IM), [1] (EXL) and [0] (IE) only; Status[22] (BEV) reads 1; all other Status bits read 0.
REQ-026 SHALL accept MTC0 writes to Cause bits [9:8] (software IP) only; writes to EPC and Compare are full width; BadVAddr is read-only.
REQ-027 SHALL, on exc_valid_i with Status.EXL=0, set EPC to exc_pc_i-4 if exc_bd_i else exc_pc_i, set Cause[31] to exc_bd_i, Cause[6:2] to exc_code_i, and Status.EXL to 1.
REQ-028 SHALL, on exc_valid_i with Status.EXL=1, update Cause[6:2] only; EPC and Cause.BD hold.
REQ-029 SHALL load BadVAddr from exc_badvaddr_i on exc_valid_i when exc_code_i is 4 or 5, regardless of EXL.
REQ-030 SHALL clear Status.EXL on eret_i; if exc_valid_i is also asserted, the exception takes priority and eret_i is ignored.
REQ-031 SHALL give an exception priority over a same-cycle MTC0 to Status, Cause or EPC for the fields the exception updates; other written fields still update.
REQ-032 SHALL register int_req_o = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), so it updates one cycle after its inputs change.
REQ-033 SHALL make rdata_o reflect register state only, not same-cycle writes.

Reset
REQ-034 SHALL reset Count, Compare, EPC, BadVAddr and Cause to 0, and Status to 0x00400000.
REQ-035 SHALL reset int_req_o and timer_int_o to 0; reset overrides any concurrent exception, eret or write.

Verification
REQ-036 SHALL cover: after reset, write Compare=5 at Count=0 -> timer_int_o=1 after the cycle Count==5; write Compare=0 -> timer_int_o=0 next cycle.
REQ-037 SHALL cover: exception with exc_code_i=4, exc_pc_i=0x80001000, exc_bd_i=1, exc_badvaddr_i=0x13 -> EPC=0x80000FFC, Cause=0x80000010, BadVAddr=0x13, Status.EXL=1.
REQ-038 SHALL cover: a second exception (code 10) while EXL=1 -> EPC unchanged, Cause[6:2]=10; then eret_i -> EXL=0.
REQ-039 SHALL cover: Status=0x00000401 and int_i[0]=1 -> int_req_o=1 one cycle after Cause[10] sets; Status.EXL=1 -> int_req_o=0.
REQ-040 SHALL cover: MTC0 Count=0xFFFFFFFF -> reads 0 two cycles later; a simultaneous exc_valid_i and eret_i -> EXL=1.

Source files
------------

// File: rtl/cp0_ctrl.sv
// CP0 system-control block: Count/Compare timer, Status/Cause/EPC/BadVAddr,
// exception entry/return bookkeeping and a registered interrupt request.
module cp0_ctrl #(
    parameter int          DATA_W   = 32,  // only 32 is meaningful
    parameter int          N_HWINT  = 6,   // 1..6 hardware lines on IP2..IP7
    parameter int unsigned TIMER_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [N_HWINT-1:0] int_i,
    input  logic              exc_valid_i,
    input  logic [4:0]        exc_code_i,
    input  logic [DATA_W-1:0] exc_pc_i,
    input  logic              exc_bd_i,
    input  logic [DATA_W-1:0] exc_badvaddr_i,
    input  logic              eret_i,
    output logic [DATA_W-1:0] status_o,
    output logic [DATA_W-1:0] cause_o,
    output logic [DATA_W-1:0] epc_o,
    output logic              int_req_o,
    output logic              timer_int_o
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic [DATA_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0]  compare_q, compare_d;
    logic [DATA_W-1:0]  epc_q, epc_d;
    logic [DATA_W-1:0]  badvaddr_q, badvaddr_d;
    logic [7:0]         im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic               bd_q, bd_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [1:0]         sw_ip_q, sw_ip_d;
    logic [N_HWINT-1:0] hw_ip_q, hw_ip_d;
    logic               ti_q, ti_d;
    logic               int_req_q, int_req_d;

    logic               wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic               timer_match;
    logic               badvaddr_exc;
    logic [7:0]         cause_ip;

    assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
    assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);
    assign wr_status  = we_i && (waddr_i == ADDR_STATUS);
    assign wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
    assign wr_epc     = we_i && (waddr_i == ADDR_EPC);

    assign timer_match  = (count_q == compare_q) && (compare_q != '0);
    assign badvaddr_exc = (exc_code_i == 5'd4) || (exc_code_i == 5'd5);

    // IP7 is shared: the top hardware line (when N_HWINT=6) ORs with the timer.
    always_comb begin
        cause_ip              = '0;
        cause_ip[1:0]         = sw_ip_q;
        cause_ip[N_HWINT+1:2] = hw_ip_q;
        if (TIMER_EN != 0) begin
            cause_ip[7] = cause_ip[7] | ti_q;
        end
    end

    always_comb begin
        count_d    = wr_count ? wdata_i : count_q + DATA_W'(1);
        compare_d  = wr_compare ? wdata_i : compare_q;
        hw_ip_d    = int_i;
        sw_ip_d    = wr_cause ? wdata_i[9:8] : sw_ip_q;
        im_d       = wr_status ? wdata_i[15:8] : im_q;
        ie_d       = wr_status ? wdata_i[0] : ie_q;
        exl_d      = wr_status ? wdata_i[1] : exl_q;
        epc_d      = wr_epc ? wdata_i : epc_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        badvaddr_d = badvaddr_q;
        ti_d       = 1'b0;

        if (TIMER_EN != 0) begin
            if (wr_compare) begin
                ti_d = 1'b0;
            end else if (timer_match) begin
                ti_d = 1'b1;
            end else begin
                ti_d = ti_q;
            end
        end

        // Exception overrides MTC0 only on the fields it actually updates;
        // a nested exception (EXL already set) leaves EPC, BD and EXL alone.
        if (exc_valid_i) begin
            exc_code_d = exc_code_i;
            if (!exl_q) begin
                epc_d = exc_bd_i ? (exc_pc_i - DATA_W'(4)) : exc_pc_i;
                bd_d  = exc_bd_i;
                exl_d = 1'b1;
            end
            if (badvaddr_exc) begin
                badvaddr_d = exc_badvaddr_i;
            end
        end else if (eret_i) begin
            exl_d = 1'b0;
        end

        int_req_d = ie_q & ~exl_q & (|(cause_ip & im_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            sw_ip_q    <= '0;
            hw_ip_q    <= '0;
            ti_q       <= 1'b0;
            int_req_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            sw_ip_q    <= sw_ip_d;
            hw_ip_q    <= hw_ip_d;
            ti_q       <= ti_d;
            int_req_q  <= int_req_d;
        end
    end

    // BEV (bit 22) is hard-wired to 1.
    assign status_o    = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o     = {bd_q, 15'b0, cause_ip, 1'b0, exc_code_q, 2'b0};
    assign epc_o       = epc_q;
    assign int_req_o   = int_req_q;
    assign timer_int_o = ti_q;

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            ADDR_BADVADDR: rdata_o = badvaddr_q;
            ADDR_COUNT:    rdata_o = count_q;
            ADDR_COMPARE:  rdata_o = compare_q;
            ADDR_STATUS:   rdata_o = status_o;
            ADDR_CAUSE:    rdata_o = cause_o;
            ADDR_EPC:      rdata_o = epc_q;
            default:       rdata_o = '0;
        endcase
    end

endmodule
